// File: rtl/dec_lag3_pipe_if.sv
// Request/result bundle for the pitch-lag decoder stage.
// Optional err_count signal is present when PITCH_ERR_COUNT_EN is defined.
interface dec_lag3_pipe_if;
  logic        start;
  logic [15:0] pitch_index;
  logic [15:0] parity_sum;
  logic        bfi;
  logic        subframe;
  logic        done;
  logic [15:0] T0;
  logic [15:0] T0_frac;
  logic        bad_pitch;
`ifdef PITCH_ERR_COUNT_EN
  logic [15:0] err_count;

  modport master (output start, pitch_index, parity_sum, bfi, subframe,
                  input  done, T0, T0_frac, bad_pitch, err_count);
  modport slave  (input  start, pitch_index, parity_sum, bfi, subframe,
                  output done, T0, T0_frac, bad_pitch, err_count);
`else
  modport master (output start, pitch_index, parity_sum, bfi, subframe,
                  input  done, T0, T0_frac, bad_pitch);
  modport slave  (input  start, pitch_index, parity_sum, bfi, subframe,
                  output done, T0, T0_frac, bad_pitch);
`endif
endinterface

// File: rtl/dec_lag3_pipe.sv
// G.729 Dec_lag3 pitch-lag decoder with bad-pitch / erasure concealment.
// Define PITCH_ERR_COUNT_EN to add the saturating parity-error counter err_count.
module dec_lag3_pipe #(
  parameter logic [15:0] PIT_MIN     = 16'd20,
  parameter logic [15:0] PIT_MAX     = 16'd143,
  parameter logic [15:0] OLD_T0_INIT = 16'd60
) (
  input logic            clk,
  input logic            reset,
  dec_lag3_pipe_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CALC  = 3'd1;
  localparam logic [2:0] S_LAG   = 3'd2;
  localparam logic [2:0] S_WIN   = 3'd3;
  localparam logic [2:0] S_CLAMP = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  function automatic logic conceal_f(input logic bfi, input logic sf, input logic par);
    return bfi | (~sf & par);
  endfunction

  logic [2:0]  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        par_q, par_d, bfi_q, bfi_d, sf_q, sf_d;
  logic        conceal_q, conceal_d;
  logic [15:0] q_q, q_d, t0_q, t0_d, frac_q, frac_d;
  logic [15:0] win_min_q, win_min_d, win_max_q, win_max_d;
  logic [15:0] t0_min_q, t0_min_d, t0_max_q, t0_max_d, old_t0_q, old_t0_d;
  logic        done_q, done_d, bad_q, bad_d;
  logic [15:0] t0_out_q, t0_out_d, frac_out_q, frac_out_d;
  logic [22:0] prod_s;
  logic [15:0] lag_s, i_s, wmin_s;
  logic        unused_s;
`ifdef PITCH_ERR_COUNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;
`endif

  assign unused_s = ^{bus.pitch_index[15:8], bus.parity_sum[15:1], prod_s[22], prod_s[14:0]};

  // Next-state and datapath for the six-step decode sequence.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    par_d      = par_q;
    bfi_d      = bfi_q;
    sf_d       = sf_q;
    conceal_d  = conceal_q;
    q_d        = q_q;
    t0_d       = t0_q;
    frac_d     = frac_q;
    win_min_d  = win_min_q;
    win_max_d  = win_max_q;
    t0_min_d   = t0_min_q;
    t0_max_d   = t0_max_q;
    old_t0_d   = old_t0_q;
`ifdef PITCH_ERR_COUNT_EN
    err_cnt_d  = err_cnt_q;
`endif
    // (idx+2)*10923 >> 15 equals floor((idx+2)/3) over the 8-bit index range
    prod_s     = ({15'd0, idx_q} + 23'd2) * 23'd10923;
    lag_s      = q_q + 16'd19;
    i_s        = q_q - 16'd1;
    wmin_s     = ((t0_q - 16'd5) < PIT_MIN) ? PIT_MIN : (t0_q - 16'd5);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          idx_d   = bus.pitch_index[7:0];
          par_d   = bus.parity_sum[0];
          bfi_d   = bus.bfi;
          sf_d    = bus.subframe;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        q_d       = {9'd0, prod_s[21:15]};
        conceal_d = conceal_f(bfi_q, sf_q, par_q);
        state_d   = S_LAG;
      end
      S_LAG: begin
        if (conceal_q) begin
          t0_d   = old_t0_q;
          frac_d = 16'd0;
        end else if (!sf_q && (idx_q < 8'd197)) begin
          t0_d   = lag_s;
          frac_d = {8'd0, idx_q} - (lag_s + lag_s + lag_s) + 16'd58;
        end else if (!sf_q) begin
          t0_d   = {8'd0, idx_q} - 16'd112;
          frac_d = 16'd0;
        end else begin
          t0_d   = t0_min_q + i_s;
          frac_d = {8'd0, idx_q} - 16'd2 - (i_s + i_s + i_s);
        end
        state_d = S_WIN;
      end
      S_WIN: begin
        if (!sf_q && !conceal_q) begin
          win_min_d = wmin_s;
          win_max_d = wmin_s + 16'd9;
        end else begin
          win_min_d = win_min_q;
          win_max_d = win_max_q;
        end
        state_d = S_CLAMP;
      end
      S_CLAMP: begin
        if (!sf_q && !conceal_q && (win_max_q > PIT_MAX)) begin
          t0_max_d = PIT_MAX;
          t0_min_d = PIT_MAX - 16'd9;
        end else if (!sf_q && !conceal_q) begin
          t0_max_d = win_max_q;
          t0_min_d = win_min_q;
        end else begin
          t0_max_d = t0_max_q;
          t0_min_d = t0_min_q;
        end
        if (conceal_q) begin
          old_t0_d = (old_t0_q >= PIT_MAX) ? PIT_MAX : (old_t0_q + 16'd1);
        end else begin
          old_t0_d = t0_q;
        end
`ifdef PITCH_ERR_COUNT_EN
        if (conceal_q && !bfi_q && (err_cnt_q != 16'hFFFF)) begin
          err_cnt_d = err_cnt_q + 16'd1;
        end else begin
          err_cnt_d = err_cnt_q;
        end
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d     = (state_q == S_DONE);
    t0_out_d   = (state_q == S_DONE) ? t0_q      : t0_out_q;
    frac_out_d = (state_q == S_DONE) ? frac_q    : frac_out_q;
    bad_d      = (state_q == S_DONE) ? conceal_q : bad_q;
  end

  // State, working and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 8'd0;
      par_q      <= 1'b0;
      bfi_q      <= 1'b0;
      sf_q       <= 1'b0;
      conceal_q  <= 1'b0;
      q_q        <= 16'd0;
      t0_q       <= 16'd0;
      frac_q     <= 16'd0;
      win_min_q  <= PIT_MIN;
      win_max_q  <= PIT_MIN + 16'd9;
      t0_min_q   <= PIT_MIN;
      t0_max_q   <= PIT_MIN + 16'd9;
      old_t0_q   <= OLD_T0_INIT;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
      t0_out_q   <= 16'd0;
      frac_out_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      bfi_q      <= bfi_d;
      sf_q       <= sf_d;
      conceal_q  <= conceal_d;
      q_q        <= q_d;
      t0_q       <= t0_d;
      frac_q     <= frac_d;
      win_min_q  <= win_min_d;
      win_max_q  <= win_max_d;
      t0_min_q   <= t0_min_d;
      t0_max_q   <= t0_max_d;
      old_t0_q   <= old_t0_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
      t0_out_q   <= t0_out_d;
      frac_out_q <= frac_out_d;
    end
  end

`ifdef PITCH_ERR_COUNT_EN
  // Saturating count of parity-only concealments.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_count = err_cnt_q;
`endif

  assign bus.done      = done_q;
  assign bus.T0        = t0_out_q;
  assign bus.T0_frac   = frac_out_q;
  assign bus.bad_pitch = bad_q;

endmodule

// File: tb/tb_dec_lag3_pipe.sv
// Self-checking bench for dec_lag3_pipe: directed scenarios plus randomized
// requests against an integer reference model of the lag decode rules.
module tb_dec_lag3_pipe;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  int   m_old, m_min, m_max, m_err;
  logic [15:0] exp_t0, exp_frac;
  logic        exp_bad;

  dec_lag3_pipe_if bus_if ();

  dec_lag3_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_old = 60;
    m_min = 20;
    m_max = 29;
    m_err = 0;
  endtask

  // Reference: plain integer arithmetic with true division by 3.
  task automatic model(input int idx, input bit par, input bit bfi, input bit sf);
    int  q, t0, fr, i;
    bit  conceal;
    conceal = bfi || (!sf && par);
    q = (idx + 2) / 3;
    if (conceal) begin
      t0 = m_old;
      fr = 0;
    end else if (!sf && idx < 197) begin
      t0 = q + 19;
      fr = idx - 3 * t0 + 58;
    end else if (!sf) begin
      t0 = idx - 112;
      fr = 0;
    end else begin
      i  = q - 1;
      t0 = m_min + i;
      fr = idx - 2 - 3 * i;
    end
    if (!sf && !conceal) begin
      m_min = (t0 - 5 < 20) ? 20 : t0 - 5;
      m_max = m_min + 9;
      if (m_max > 143) begin
        m_max = 143;
        m_min = 134;
      end
    end
    if (conceal) m_old = (m_old + 1 > 143) ? 143 : m_old + 1;
    else         m_old = t0;
    if (conceal && !bfi && m_err < 65535) m_err++;
    exp_t0   = t0[15:0];
    exp_frac = fr[15:0];
    exp_bad  = conceal;
  endtask

  task automatic run_req(input string tag, input logic [7:0] idx, input logic par,
                         input logic bfi, input logic sf, input logic spam);
    int got;
    int lat;
    int extra;
    model(idx, par, bfi, sf);
    @(posedge clk); #1;
    bus_if.start       = 1'b1;
    bus_if.pitch_index = {8'($urandom_range(0, 255)), idx};
    bus_if.parity_sum  = {15'($urandom_range(0, 32767)), par};
    bus_if.bfi         = bfi;
    bus_if.subframe    = sf;
    @(posedge clk); #1;
    bus_if.start = spam;
    got = 0;
    lat = 0;
    for (int c = 1; c <= 12 && got == 0; c++) begin
      @(posedge clk); #1;
      if (spam && c <= 3) begin
        bus_if.start       = 1'b1;
        bus_if.pitch_index = 16'($urandom_range(0, 65535));
        bus_if.bfi         = ~bfi;
        bus_if.subframe    = ~sf;
      end else begin
        bus_if.start = 1'b0;
      end
      if (bus_if.done === 1'b1) begin
        got = 1;
        lat = c;
      end
    end
    bus_if.start = 1'b0;
    chk({tag, "_done_seen"}, 16'(got), 16'd1);
    chk({tag, "_latency"},   16'(lat), 16'd5);
    chk({tag, "_T0"},        bus_if.T0, exp_t0);
    chk({tag, "_T0_frac"},   bus_if.T0_frac, exp_frac);
    chk({tag, "_bad_pitch"}, {15'd0, bus_if.bad_pitch}, {15'd0, exp_bad});
`ifdef PITCH_ERR_COUNT_EN
    chk({tag, "_err_count"}, bus_if.err_count, m_err[15:0]);
`endif
    extra = 0;
    for (int c = 0; c < (spam ? 8 : 1); c++) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) extra++;
    end
    chk({tag, "_single_pulse"}, 16'(extra), 16'd0);
    chk({tag, "_T0_hold"}, bus_if.T0, exp_t0);
  endtask

  initial begin
    int done_cnt;
    n_checks = 0;
    n_fail   = 0;
    reset              = 1'b0;
    bus_if.start       = 1'b0;
    bus_if.pitch_index = 16'd0;
    bus_if.parity_sum  = 16'd0;
    bus_if.bfi         = 1'b0;
    bus_if.subframe    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done",    {15'd0, bus_if.done}, 16'd0);
    chk("rst_T0",      bus_if.T0, 16'd0);
    chk("rst_T0_frac", bus_if.T0_frac, 16'd0);
    chk("rst_bad",     {15'd0, bus_if.bad_pitch}, 16'd0);
    reset = 1'b1;

    run_req("sf0_idx0",   8'd0,   1'b0, 1'b0, 1'b0, 1'b0);
    run_req("sf0_idx196", 8'd196, 1'b0, 1'b0, 1'b0, 1'b0);
    run_req("sf0_idx200", 8'd200, 1'b0, 1'b0, 1'b0, 1'b0);
    run_req("sf1_idx4",   8'd4,   1'b0, 1'b0, 1'b1, 1'b0);
    run_req("sf1_par_ign",8'd4,   1'b1, 1'b0, 1'b1, 1'b0);
    run_req("sf0_idx255", 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    run_req("sf1_clamp",  8'd10,  1'b0, 1'b0, 1'b1, 1'b0);
    run_req("sf0_idx255b",8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    run_req("par_at_max", 8'd17,  1'b1, 1'b0, 1'b0, 1'b0);
    run_req("old_sat",    8'd0,   1'b0, 1'b1, 1'b1, 1'b0);
    run_req("sf0_idx200b",8'd200, 1'b0, 1'b0, 1'b0, 1'b0);
    run_req("par_err",    8'd99,  1'b1, 1'b0, 1'b0, 1'b0);
    run_req("bfi_sf1",    8'd50,  1'b0, 1'b1, 1'b1, 1'b0);
    run_req("win_kept",   8'd4,   1'b0, 1'b0, 1'b1, 1'b0);
    run_req("sf1_idx0",   8'd0,   1'b0, 1'b0, 1'b1, 1'b0);
    run_req("busy_spam",  8'd120, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort a request with reset while it sits in the lag step.
    @(posedge clk); #1;
    bus_if.start       = 1'b1;
    bus_if.pitch_index = 16'd30;
    bus_if.parity_sum  = 16'd0;
    bus_if.bfi         = 1'b0;
    bus_if.subframe    = 1'b0;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    chk("abort_done",    {15'd0, bus_if.done}, 16'd0);
    chk("abort_T0",      bus_if.T0, 16'd0);
    chk("abort_T0_frac", bus_if.T0_frac, 16'd0);
    chk("abort_bad",     {15'd0, bus_if.bad_pitch}, 16'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus_if.done === 1'b1) done_cnt++;
    end
    chk("abort_no_done", 16'(done_cnt), 16'd0);
    run_req("old_t0_init", 8'd77, 1'b0, 1'b1, 1'b1, 1'b0);
    run_req("win_init",    8'd4,  1'b0, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      run_req("rand",
              8'($urandom_range(0, 255)),
              ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 4) == 0),
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_lag3_pipe.md
Name: dec_lag3_pipe

Overview:
Decoder pitch-lag stage, directly downstream of the parity-check stage. Consumes the parity `sum` result together with the 8-bit adaptive-codebook index, erasure flag and subframe number. Produces the integer lag T0 and fractional lag T0_frac per G.729 Dec_lag3, including bad-pitch and erasure concealment. Holds the cross-subframe state old_T0, T0_min and T0_max; its outputs feed the adaptive-codebook interpolation stage.

Parameters:
PIT_MIN, 20, minimum integer pitch lag
PIT_MAX, 143, maximum integer pitch lag
OLD_T0_INIT, 60, reset value of old_T0

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (low = reset asserted)
start  in  1  one-shot request; sampled only in IDLE
pitch_index  in  16  P1 (subframe 0) or P2 (subframe 1) index; bits [7:0] used
parity_sum  in  16  sum output of the parity-check stage; bit 0 used (1 = parity error)
bfi  in  1  bad-frame (erasure) indicator
subframe  in  1  0 = first subframe, 1 = second subframe
done  out  1  one-cycle completion pulse
T0  out  16  integer lag, unsigned
T0_frac  out  16  fractional lag, two's complement, range -1..1
bad_pitch  out  1  concealment path taken on this request

Behaviour:
- Reset (reset low, asynchronous): state = IDLE, done = 0, T0 = 0, T0_frac = 0, bad_pitch = 0, old_T0 = OLD_T0_INIT, T0_min = PIT_MIN, T0_max = PIT_MIN+9. A reset during any state aborts the request; no done pulse is issued.
- FSM: IDLE -> CALC -> LAG -> WIN -> CLAMP -> DONE -> IDLE.
- IDLE: on start=1, latch pitch_index[7:0], parity_sum[0], bfi and subframe, then go to CALC. While not in IDLE, start is ignored and is not queued.
- CALC: q = ((idx+2)*10923) >> 15, an unsigned 15-bit constant multiply that gives the exact floor((idx+2)/3) for idx ≤ 255. Concealment condition: conceal = bfi OR (subframe==0 AND parity bit).
- LAG:
  - conceal: T0 = old_T0, T0_frac = 0.
  - subframe 0, idx < 197: T0 = q + 19, T0_frac = idx - 3*T0 + 58.
  - subframe 0, idx ≥ 197: T0 = idx - 112, T0_frac = 0.
  - subframe 1: i = q - 1, T0 = T0_min + i, T0_frac = idx - 2 - 3*i.
  - All arithmetic is 16-bit two's complement.
- WIN: only when subframe 0 and not conceal: T0_min' = T0 - 5, clamped up to PIT_MIN; T0_max' = T0_min' + 9.
- CLAMP:
  - If T0_max' > PIT_MAX, then T0_max = PIT_MAX and T0_min = PIT_MAX - 9; otherwise commit T0_min' and T0_max'.
  - Non-conceal: old_T0 = T0.
  - Conceal: old_T0 = min(old_T0 + 1, PIT_MAX).
  - Concealment and subframe 1 leave T0_min and T0_max unchanged.
- DONE: done = 1 for exactly one cycle.
  - Latency: done is high in the cycle following the 5th rising edge after the edge that sampled start.
  - T0, T0_frac and bad_pitch (= conceal) are valid while done = 1 and hold until the next DONE.
  - The earliest next start is sampled on the edge that leaves DONE.
- The parity bit is ignored when subframe = 1; only bfi forces concealment there.

Optional Feature:
PITCH_ERR_COUNT_EN:
- Defined: adds output err_count [15:0].
  - Increments by 1 in CLAMP whenever conceal = 1 and bfi = 0 (true parity errors only), saturating at 16'hFFFF.
  - Reset value is 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then subframe 0, idx=0, parity 0, bfi 0 -> T0=19, T0_frac=1, T0_min=20 (clamped), T0_max=29, bad_pitch=0, done exactly 5 cycles after start.
- Subframe 0, idx=196 -> T0=85, T0_frac=16'hFFFF (-1). Next, subframe 0, idx=200 -> T0=88, frac 0, T0_min=83, T0_max=92.
- After the idx=200 request: subframe 1, idx=4 -> T0=84, T0_frac=-1. Subframe 1 with parity_sum=1 is ignored -> normal decode.
- Subframe 0, idx=255 -> T0=143, T0_max clamps to 143, T0_min=134. Then parity error on subframe 0 -> T0=143, frac 0, bad_pitch=1, old_T0 stays 143.
- After the idx=200 request: parity error on subframe 0 -> T0=88, old_T0=89. Then bfi=1 on subframe 1 -> T0=89, frac 0, old_T0=90. T0_min/T0_max remain 83/92 throughout.
- Assert reset in the LAG state -> no done pulse, outputs 0, old_T0=60. Start pulses issued while busy -> ignored, exactly one done pulse.
